// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between pfu and lsu; optional MEM_ARBITER_ROUND_ROBIN_EN
module mem_arbiter #(
  parameter int C_BUS_SZX = 5,
  parameter int C_OUTSTANDING_X = 2,
  localparam int C_BUS_SZ = 2**C_BUS_SZX
) (
  input  logic                  clk_i,
  input  logic                  resetb_i,
  input  logic                  clk_en_i,
  input  logic                  ireqvalid_i,
  output logic                  ireqready_o,
  input  logic [1:0]            ireqhpl_i,
  input  logic [C_BUS_SZ-1:0]   ireqaddr_i,
  output logic                  irspvalid_o,
  input  logic                  irspready_i,
  output logic                  irsprerr_o,
  output logic [C_BUS_SZ-1:0]   irspdata_o,
  input  logic                  dreqvalid_i,
  output logic                  dreqready_o,
  input  logic [1:0]            dreqhpl_i,
  input  logic [C_BUS_SZ-1:0]   dreqaddr_i,
  input  logic                  dreqwe_i,
  input  logic [C_BUS_SZ/8-1:0] dreqbe_i,
  input  logic [C_BUS_SZ-1:0]   dreqdata_i,
  output logic                  drspvalid_o,
  input  logic                  drspready_i,
  output logic                  drsprerr_o,
  output logic [C_BUS_SZ-1:0]   drspdata_o,
  output logic                  mreqvalid_o,
  input  logic                  mreqready_i,
  output logic [1:0]            mreqhpl_o,
  output logic [C_BUS_SZ-1:0]   mreqaddr_o,
  output logic                  mreqwe_o,
  output logic [C_BUS_SZ/8-1:0] mreqbe_o,
  output logic [C_BUS_SZ-1:0]   mreqdata_o,
  input  logic                  mrspvalid_i,
  output logic                  mrspready_o,
  input  logic                  mrsprerr_i,
  input  logic [C_BUS_SZ-1:0]   mrspdata_i,
  output logic                  idle_o,
  output logic                  proterr_o
);
  localparam int DEPTH = 2**C_OUTSTANDING_X;
  typedef enum logic [1:0] {NONE, LOCK_I, LOCK_D} lock_t;
  lock_t lock_q, lock_d;
  logic gnt, pref, gvalid, accept, full, empty, owner, pop;
  logic [DEPTH-1:0] tag_q;
  logic [C_OUTSTANDING_X-1:0] wp_q, rp_q;
  logic [C_OUTSTANDING_X:0] level_q;
  logic proterr_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_q;
  assign pref = (ireqvalid_i & dreqvalid_i) ? ~last_q : dreqvalid_i;
  // remember who won the last accepted request (1 = data)
  always_ff @(posedge clk_i or negedge resetb_i)
    if (!resetb_i) last_q <= 1'b0;
    else if (clk_en_i & accept) last_q <= gnt;
`else
  assign pref = dreqvalid_i;
`endif
  assign full  = level_q == (C_OUTSTANDING_X+1)'(DEPTH);
  assign empty = level_q == '0;
  // grant lock register
  always_ff @(posedge clk_i or negedge resetb_i)
    if (!resetb_i) lock_q <= NONE;
    else if (clk_en_i) lock_q <= lock_d;
  // grant selection, lock next state and request path
  always_comb begin
    lock_d = lock_q;
    gnt = lock_q == LOCK_I ? 1'b0 : lock_q == LOCK_D ? 1'b1 : pref;
    gvalid = gnt ? dreqvalid_i : ireqvalid_i;
    mreqvalid_o = gvalid & ~full;
    accept = mreqvalid_o & mreqready_i;
    if (accept) lock_d = NONE;
    else if (mreqvalid_o) lock_d = gnt ? LOCK_D : LOCK_I;
    ireqready_o = ~gnt & mreqready_i & ~full;
    dreqready_o = gnt & mreqready_i & ~full;
    mreqhpl_o = gnt ? dreqhpl_i : ireqhpl_i;
    mreqaddr_o = gnt ? dreqaddr_i : ireqaddr_i;
    mreqwe_o = gnt & dreqwe_i;
    mreqbe_o = gnt ? dreqbe_i : '1;
    mreqdata_o = gnt ? dreqdata_i : '0;
  end
  // response steering from the head tag; an empty FIFO swallows stray responses
  always_comb begin
    owner = tag_q[rp_q];
    mrspready_o = empty ? 1'b1 : owner ? drspready_i : irspready_i;
    irspvalid_o = mrspvalid_i & ~empty & ~owner;
    drspvalid_o = mrspvalid_i & ~empty & owner;
    pop = mrspvalid_i & mrspready_o & ~empty;
    irsprerr_o = mrsprerr_i;
    drsprerr_o = mrsprerr_i;
    irspdata_o = mrspdata_i;
    drspdata_o = mrspdata_i;
    idle_o = empty & ~ireqvalid_i & ~dreqvalid_i;
    proterr_o = proterr_q;
  end
  // in-order source tag FIFO and sticky protocol error
  always_ff @(posedge clk_i or negedge resetb_i)
    if (!resetb_i) begin
      tag_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      proterr_q <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) tag_q[wp_q] <= gnt;
      if (accept) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      level_q <= level_q + {{C_OUTSTANDING_X{1'b0}}, accept} - {{C_OUTSTANDING_X{1'b0}}, pop};
      if (mrspvalid_i & empty) proterr_q <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter request arbitration and response steering
module tb_mem_arbiter;
  logic clk = 1'b0, resetb = 1'b0, clk_en = 1'b1;
  logic ireqvalid = 0, ireqready, irspvalid, irspready = 1, irsprerr;
  logic [1:0] ireqhpl = 0;
  logic [31:0] ireqaddr = 0, irspdata;
  logic dreqvalid = 0, dreqready, dreqwe = 0, drspvalid, drspready = 1, drsprerr;
  logic [1:0] dreqhpl = 0;
  logic [3:0] dreqbe = 0;
  logic [31:0] dreqaddr = 0, dreqdata = 0, drspdata;
  logic mreqvalid, mreqready = 1, mreqwe, mrspvalid = 0, mrspready, mrsprerr = 0;
  logic [1:0] mreqhpl;
  logic [3:0] mreqbe;
  logic [31:0] mreqaddr, mreqdata, mrspdata = 0;
  logic idle, proterr;
  int total = 0, bad = 0;

  typedef struct {logic [31:0] addr; logic [38:0] attr;} req_t;
  typedef struct {logic side; logic [31:0] data;} rsp_t;
  req_t exp_req[$];
  rsp_t exp_rsp[$];

  mem_arbiter dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .ireqvalid_i(ireqvalid), .ireqready_o(ireqready), .ireqhpl_i(ireqhpl), .ireqaddr_i(ireqaddr),
    .irspvalid_o(irspvalid), .irspready_i(irspready), .irsprerr_o(irsprerr), .irspdata_o(irspdata),
    .dreqvalid_i(dreqvalid), .dreqready_o(dreqready), .dreqhpl_i(dreqhpl), .dreqaddr_i(dreqaddr),
    .dreqwe_i(dreqwe), .dreqbe_i(dreqbe), .dreqdata_i(dreqdata),
    .drspvalid_o(drspvalid), .drspready_i(drspready), .drsprerr_o(drsprerr), .drspdata_o(drspdata),
    .mreqvalid_o(mreqvalid), .mreqready_i(mreqready), .mreqhpl_o(mreqhpl), .mreqaddr_o(mreqaddr),
    .mreqwe_o(mreqwe), .mreqbe_o(mreqbe), .mreqdata_o(mreqdata),
    .mrspvalid_i(mrspvalid), .mrspready_o(mrspready), .mrsprerr_i(mrsprerr), .mrspdata_i(mrspdata),
    .idle_o(idle), .proterr_o(proterr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // instruction request: fixed attributes hpl=0, we=0, be=f, data=0
  task automatic req_i(logic [31:0] a);
    req_t r;
    ireqvalid = 1;
    ireqaddr = a;
    r.addr = a;
    r.attr = {2'd0, 1'b0, 4'hf, 32'h0};
    exp_req.push_back(r);
  endtask

  // data request: write with hpl=3, be=3, data derived from address
  task automatic req_d(logic [31:0] a);
    req_t r;
    dreqvalid = 1;
    dreqaddr = a;
    dreqhpl = 2'd3;
    dreqwe = 1;
    dreqbe = 4'h3;
    dreqdata = a ^ 32'hffff;
    r.addr = a;
    r.attr = {2'd3, 1'b1, 4'h3, a ^ 32'hffff};
    exp_req.push_back(r);
  endtask

  task automatic exp_r(logic side, logic [31:0] d);
    rsp_t e;
    e.side = side;
    e.data = d;
    exp_rsp.push_back(e);
  endtask

  // monitor: compare accepted memory requests and delivered responses against the scoreboard
  always @(negedge clk) begin
    if (resetb && clk_en) begin
      if (mreqvalid && mreqready) begin
        if (exp_req.size() == 0) chk("unexpected_req", {32'h0, mreqaddr}, 64'hdead);
        else begin
          req_t r;
          r = exp_req.pop_front();
          chk("req_addr", {32'h0, mreqaddr}, {32'h0, r.addr});
          chk("req_attr", {25'h0, mreqhpl, mreqwe, mreqbe, mreqdata}, {25'h0, r.attr});
        end
      end
      if ((irspvalid && irspready) || (drspvalid && drspready)) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", {32'h0, mrspdata}, 64'hdead);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_side", {62'h0, irspvalid, drspvalid}, {62'h0, ~e.side, e.side});
          chk("rsp_data", {32'h0, e.side ? drspdata : irspdata}, {32'h0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_idle", {63'h0, idle}, 64'h1);
    chk("reset_proterr", {63'h0, proterr}, 64'h0);
    chk("reset_mreqvalid", {63'h0, mreqvalid}, 64'h0);
    resetb = 1;
    step();
    // both valid: data first, then instruction
    req_d(32'h200);
    req_i(32'h100);
    neg();
    chk("both_dreqready", {62'h0, dreqready, ireqready}, 64'h2);
    chk("both_addr_d", {32'h0, mreqaddr}, 64'h200);
    step();
    dreqvalid = 0;
    neg();
    chk("both_addr_i", {32'h0, mreqaddr}, 64'h100);
    step();
    ireqvalid = 0;
    exp_r(1, 32'ha1);
    exp_r(0, 32'ha2);
    mrspvalid = 1;
    mrspdata = 32'ha1;
    step();
    mrspdata = 32'ha2;
    step();
    mrspvalid = 0;
    // data locked while memory stalls; instruction arrives late
    mreqready = 0;
    req_d(32'h240);
    neg();
    chk("lockd_c0", {32'h0, mreqaddr}, 64'h240);
    step();
    req_i(32'h140);
    neg();
    chk("lockd_c1", {32'h0, mreqaddr}, 64'h240);
    step();
    neg();
    chk("lockd_c2", {32'h0, mreqaddr}, 64'h240);
    step();
    mreqready = 1;
    step();
    dreqvalid = 0;
    step();
    ireqvalid = 0;
    // instruction locked; data must not steal the grant
    mreqready = 0;
    req_i(32'h500);
    neg();
    chk("locki_c0", {32'h0, mreqaddr}, 64'h500);
    step();
    req_d(32'h600);
    neg();
    chk("locki_c1", {32'h0, mreqaddr}, 64'h500);
    chk("locki_ready", {62'h0, dreqready, ireqready}, 64'h0);
    step();
    mreqready = 1;
    step();
    ireqvalid = 0;
    step();
    dreqvalid = 0;
    exp_r(1, 32'h31);
    exp_r(0, 32'h32);
    exp_r(0, 32'h33);
    exp_r(1, 32'h34);
    mrspvalid = 1;
    for (int k = 0; k < 4; k++) begin
      mrspdata = 32'h31 + k;
      step();
    end
    mrspvalid = 0;
    neg();
    chk("drain_idle", {63'h0, idle}, 64'h1);
    step();
    // fill FIFO with I,D,I,D
    req_i(32'h1000);
    step();
    ireqvalid = 0;
    req_d(32'h2000);
    step();
    dreqvalid = 0;
    req_i(32'h1004);
    step();
    ireqvalid = 0;
    req_d(32'h2004);
    step();
    dreqvalid = 0;
    req_i(32'h300);
    neg();
    chk("full_mreqvalid", {63'h0, mreqvalid}, 64'h0);
    chk("full_ireqready", {63'h0, ireqready}, 64'h0);
    chk("full_idle", {63'h0, idle}, 64'h0);
    exp_r(0, 32'ha);
    exp_r(1, 32'hb);
    exp_r(0, 32'hc);
    exp_r(1, 32'hd);
    exp_r(0, 32'he);
    mrspvalid = 1;
    mrspdata = 32'ha;
    step();
    mrspdata = 32'hb;
    neg();
    chk("pushpop_mreqvalid", {63'h0, mreqvalid}, 64'h1);
    step();
    ireqvalid = 0;
    mrspdata = 32'hc;
    step();
    mrspdata = 32'hd;
    step();
    mrspdata = 32'he;
    step();
    mrspvalid = 0;
    neg();
    chk("fill_idle", {63'h0, idle}, 64'h1);
    step();
    // data response back-pressure
    req_d(32'h400);
    step();
    dreqvalid = 0;
    exp_r(1, 32'h55);
    mrspvalid = 1;
    mrspdata = 32'h55;
    drspready = 0;
    for (int k = 0; k < 2; k++) begin
      neg();
      chk("bp_mrspready", {63'h0, mrspready}, 64'h0);
      chk("bp_valids", {62'h0, irspvalid, drspvalid}, 64'h1);
      step();
    end
    drspready = 1;
    step();
    mrspvalid = 0;
    neg();
    chk("bp_idle", {63'h0, idle}, 64'h1);
    step();
    // clock enable low: no state change
    clk_en = 0;
    ireqvalid = 1;
    ireqaddr = 32'h700;
    step();
    step();
    neg();
    chk("cen_mreqvalid", {63'h0, mreqvalid}, 64'h1);
    step();
    ireqvalid = 0;
    clk_en = 1;
    neg();
    chk("cen_idle", {63'h0, idle}, 64'h1);
    step();
    // stray response with empty FIFO
    mrspvalid = 1;
    mrspdata = 32'h77;
    neg();
    chk("stray_mrspready", {63'h0, mrspready}, 64'h1);
    chk("stray_valids", {62'h0, irspvalid, drspvalid}, 64'h0);
    chk("stray_proterr_pre", {63'h0, proterr}, 64'h0);
    step();
    mrspvalid = 0;
    neg();
    chk("stray_proterr", {63'h0, proterr}, 64'h1);
    step();
    step();
    neg();
    chk("stray_proterr_sticky", {63'h0, proterr}, 64'h1);
    #2;
    resetb = 0;
    #1;
    chk("async_reset_proterr", {63'h0, proterr}, 64'h0);
    step();
    resetb = 1;
    step();
    chk("req_queue_empty", 64'(exp_req.size()), 64'h0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
